// File: rtl/mem_access_unit.sv
// Memory-stage front end: one outstanding load/store, word-addressed bus with byte mask.
// Optional MISALIGN_TRAP_EN: misaligned halves/words complete at once with out_misalign set.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_we,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [1:0]  in_size,
  input  logic [2:0]  in_ld_sel,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [1:0]  out_byte_offset,
  output logic [2:0]  out_ld_sel,
  output logic [4:0]  out_rd,
  output logic        out_is_store,
  output logic        out_misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  ld_sel_q, ld_sel_d;
  logic [4:0]  rd_q, rd_d;
  logic        misalign_q, misalign_d;

  logic        is_byte, is_half;
  logic [1:0]  off_raw, off_eff;
  logic        mis;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_mask;

  // Lane steering of the incoming access; size 3 falls through to word.
  always_comb begin
    is_byte = (in_size == 2'd0);
    is_half = (in_size == 2'd1);
    off_raw = in_addr[1:0];
`ifdef MISALIGN_TRAP_EN
    mis     = (is_half && off_raw[0]) || (!is_byte && !is_half && (off_raw != 2'd0));
    off_eff = off_raw;
`else
    mis     = 1'b0;
    if (is_byte)      off_eff = off_raw;
    else if (is_half) off_eff = {off_raw[1], 1'b0};
    else              off_eff = 2'd0;
`endif
    if (is_byte) begin
      lane_wdata = {4{in_wdata[7:0]}};
      lane_mask  = 4'b0001 << off_eff;
    end else if (is_half) begin
      lane_wdata = {2{in_wdata[15:0]}};
      lane_mask  = 4'b0011 << off_eff;
    end else begin
      lane_wdata = in_wdata;
      lane_mask  = 4'b1111;
    end
    if (!in_we || mis) lane_mask = 4'b0000;
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    off_d      = off_q;
    ld_sel_d   = ld_sel_q;
    rd_d       = rd_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          we_d       = in_we;
          addr_d     = {in_addr[31:2], 2'b00};
          wdata_d    = lane_wdata;
          wmask_d    = lane_mask;
          rdata_d    = 32'd0;
          off_d      = off_eff;
          ld_sel_d   = in_ld_sel;
          rd_d       = in_rd;
          misalign_d = mis;
          // A trapped access never touches the bus.
          state_d    = mis ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_gnt) state_d = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wmask_q    <= 4'd0;
      rdata_q    <= 32'd0;
      off_q      <= 2'd0;
      ld_sel_q   <= 3'd0;
      rd_q       <= 5'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      rdata_q    <= rdata_d;
      off_q      <= off_d;
      ld_sel_q   <= ld_sel_d;
      rd_q       <= rd_d;
      misalign_q <= misalign_d;
    end
  end

  // Every output is a register or a decode of state_q only.
  assign in_ready        = (state_q == IDLE);
  assign mem_req         = (state_q == REQ);
  assign mem_we          = we_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_wmask       = wmask_q;
  assign out_valid       = (state_q == RESP);
  assign out_rdata       = rdata_q;
  assign out_byte_offset = off_q;
  assign out_ld_sel      = ld_sel_q;
  assign out_rd          = rd_q;
  assign out_is_store    = we_q;
  assign out_misalign    = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random loads/stores against a lane-rule model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_we;
  logic [31:0] in_addr, in_wdata;
  logic [1:0]  in_size;
  logic [2:0]  in_ld_sel;
  logic [4:0]  in_rd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_rdata;
  logic [1:0]  out_byte_offset;
  logic [2:0]  out_ld_sel;
  logic [4:0]  out_rd;
  logic        out_is_store, out_misalign;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_size(in_size), .in_ld_sel(in_ld_sel), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_byte_offset(out_byte_offset), .out_ld_sel(out_ld_sel), .out_rd(out_rd),
    .out_is_store(out_is_store), .out_misalign(out_misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: byte enables, replicated data, reported offset and trap flag from the lane rules.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, output logic [31:0] e_wdata,
                       output logic [3:0] e_mask, output logic [1:0] e_off, output bit e_mis);
    int off, eoff, nbytes;
    off    = int'(addr % 4);
    nbytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
`ifdef MISALIGN_TRAP_EN
    e_mis = (off % nbytes) != 0;
    eoff  = off;
`else
    e_mis = 1'b0;
    eoff  = (off / nbytes) * nbytes;
`endif
    if (nbytes == 1)      e_wdata = (wdata % 256) * 32'h0101_0101;
    else if (nbytes == 2) e_wdata = (wdata % 65536) * 32'h0001_0001;
    else                  e_wdata = wdata;
    e_mask = 4'd0;
    if (we && !e_mis)
      for (int b = 0; b < 4; b++)
        if (b >= eoff && b < eoff + nbytes) e_mask[b] = 1'b1;
    e_off = 2'(eoff);
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic [2:0] ld_sel, input logic [4:0] rd,
                        input int g, input int r, input logic [31:0] rdata, input int hold,
                        input bit spur);
    logic [31:0] e_wdata;
    logic [3:0]  e_mask;
    logic [1:0]  e_off;
    bit          e_mis;
    int          acc, n, lat;
    model(we, addr, wdata, size, e_wdata, e_mask, e_off, e_mis);
    n = 0;
    while (!in_ready && n < 8) begin step(); n++; end
    check("in_ready_idle", 32'(in_ready), 1);
    if (spur) begin mem_rvalid = 1'b1; mem_rdata = $urandom; end
    in_valid = 1'b1; in_we = we; in_addr = addr; in_wdata = wdata;
    in_size = size; in_ld_sel = ld_sel; in_rd = rd;
    acc = cyc;
    step();
    in_valid = 1'b0; mem_rvalid = 1'b0;
    in_we = $urandom; in_addr = $urandom; in_wdata = $urandom;
    in_ld_sel = 3'($urandom); in_rd = 5'($urandom);
    if (!e_mis) begin
      check("req", 32'(mem_req), 1);
      check("out_valid_req", 32'(out_valid), 0);
      check("mem_we", 32'(mem_we), 32'(we));
      check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      check("mem_wmask", 32'(mem_wmask), 32'(e_mask));
      if (we) check("mem_wdata", mem_wdata, e_wdata);
      if (spur) begin mem_rvalid = 1'b1; mem_rdata = $urandom; end
      for (int i = 0; i < g; i++) begin
        step();
        mem_rvalid = 1'b0;
        check("req_hold", 32'(mem_req), 1);
        check("addr_hold", mem_addr, addr & 32'hFFFF_FFFC);
        check("in_ready_busy", 32'(in_ready), 0);
      end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!we) begin
        for (int i = 0; i < r; i++) begin
          check("wait_noreq", 32'(mem_req), 0);
          check("wait_nvalid", 32'(out_valid), 0);
          step();
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        step();
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
    end else begin
      check("mis_noreq", 32'(mem_req), 0);
    end
    lat = e_mis ? 1 : (we ? 2 + g : 3 + g + r);
    check("out_valid", 32'(out_valid), 1);
    check("latency", 32'(cyc - acc), 32'(lat));
    for (int i = 0; i <= hold; i++) begin
      check("resp_valid", 32'(out_valid), 1);
      check("in_ready_resp", 32'(in_ready), 0);
      check("out_rdata", out_rdata, (we || e_mis) ? 32'd0 : rdata);
      check("out_off", 32'(out_byte_offset), 32'(e_off));
      check("out_ld_sel", 32'(out_ld_sel), 32'(ld_sel));
      check("out_rd", 32'(out_rd), 32'(rd));
      check("out_is_store", 32'(out_is_store), 32'(we));
      check("out_misalign", 32'(out_misalign), 32'(e_mis));
      if (i < hold) begin
        out_ready = 1'b0;
        if (spur) begin mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom; end
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("done_nvalid", 32'(out_valid), 0);
    check("done_ready", 32'(in_ready), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"}, 32'(mem_req), 0);
    check({tag, "_we"}, 32'(mem_we), 0);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_wmask"}, 32'(mem_wmask), 0);
    check({tag, "_rdata"}, out_rdata, 0);
    check({tag, "_attr"}, {22'd0, out_byte_offset, out_ld_sel, out_rd}, 0);
    check({tag, "_flags"}, {30'd0, out_is_store, out_misalign}, 0);
    check({tag, "_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 0; in_we = 0; in_addr = 0; in_wdata = 0; in_size = 0;
    in_ld_sel = 0; in_rd = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; out_ready = 0;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();

    // Byte store with grant in the first REQ cycle.
    access(1'b1, 32'h0000_1003, 32'h0000_00AB, 2'd0, 3'd0, 5'd0, 0, 0, 32'd0, 0, 1'b0);
    // Half load with delayed grant and response, held result, spurious pulses.
    access(1'b0, 32'h0000_2002, 32'd0, 2'd1, 3'd5, 5'd17, 3, 1, 32'h80FF_1234, 4, 1'b1);
    // Word load at a misaligned address.
    access(1'b0, 32'h0000_3001, 32'd0, 2'd2, 3'd2, 5'd9, 0, 0, 32'h1357_9BDF, 0, 1'b0);

    // Reset in WAIT, late response must be dropped.
    in_valid = 1'b1; in_we = 1'b0; in_addr = 32'h0000_4004; in_size = 2'd2;
    in_ld_sel = 3'd3; in_rd = 5'd7;
    step();
    in_valid = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("wait_entered", 32'(out_valid), 0);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    check("late_nvalid", 32'(out_valid), 0);
    check("late_rdata", out_rdata, 0);
    check("late_ready", 32'(in_ready), 1);
    access(1'b0, 32'h0000_4008, 32'd0, 2'd2, 3'd1, 5'd3, 1, 0, 32'hCAFE_F00D, 1, 1'b0);

    for (int k = 0; k < 100; k++) begin
      access(1'($urandom), $urandom, $urandom, 2'($urandom_range(0, 3)),
             3'($urandom), 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom, $urandom_range(0, 2), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
